// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg -- shared state encoding, defaults and requester indices.  Rev 1.0
`default_nettype none

package ram_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int LENW_DEFAULT = 8;

  localparam logic REQ_S0 = 1'b0;
  localparam logic REQ_S1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if -- requester S0/S1 handshakes plus RAM port A, one bundle.  Rev 1.0
`default_nettype none

interface ram_arbiter_if #(
  parameter int WIDTH = 10,
  parameter int LENW  = ram_arbiter_pkg::LENW_DEFAULT
);

  logic             S0_REQ,    S1_REQ;
  logic             S0_WE,     S1_WE;
  logic [WIDTH-1:0] S0_ADDR,   S1_ADDR;
  logic [LENW-1:0]  S0_LEN,    S1_LEN;
  logic [31:0]      S0_WDATA,  S1_WDATA;
  logic             S0_GNT,    S1_GNT;
  logic             S0_BEAT,   S1_BEAT;
  logic             S0_RVALID, S1_RVALID;
  logic [31:0]      S0_RDATA,  S1_RDATA;
  logic             S0_DONE,   S1_DONE;

  logic             M_RDEN;
  logic [WIDTH-1:0] M_RADDR;
  logic             M_WREN;
  logic [WIDTH-1:0] M_WADDR;
  logic [31:0]      M_WDATA;
  logic [31:0]      M_RDATA;

  // Requesters and the RAM model sit on the master side.
  modport master (
    output S0_REQ, S0_WE, S0_ADDR, S0_LEN, S0_WDATA,
    output S1_REQ, S1_WE, S1_ADDR, S1_LEN, S1_WDATA,
    input  S0_GNT, S0_BEAT, S0_RVALID, S0_RDATA, S0_DONE,
    input  S1_GNT, S1_BEAT, S1_RVALID, S1_RDATA, S1_DONE,
    input  M_RDEN, M_RADDR, M_WREN, M_WADDR, M_WDATA,
    output M_RDATA
  );

  modport slave (
    input  S0_REQ, S0_WE, S0_ADDR, S0_LEN, S0_WDATA,
    input  S1_REQ, S1_WE, S1_ADDR, S1_LEN, S1_WDATA,
    output S0_GNT, S0_BEAT, S0_RVALID, S0_RDATA, S0_DONE,
    output S1_GNT, S1_BEAT, S1_RVALID, S1_RDATA, S1_DONE,
    output M_RDEN, M_RADDR, M_WREN, M_WADDR, M_WDATA,
    input  M_RDATA
  );

endinterface

`default_nettype wire

// File: rtl/ram_arbiter_pick.sv
// ram_arbiter_pick -- winner select from {S1_REQ, S0_REQ}.  Rev 1.0
// Build option RAM_ARBITER_RR_EN: round-robin on ties; otherwise S0 fixed priority.
`default_nettype none

module ram_arbiter_pick (
  input  wire [1:0] i_req,
`ifdef RAM_ARBITER_RR_EN
  input  wire       i_last,
`endif
  output logic      o_any,
  output logic      o_win
);

  assign o_any = |i_req;

`ifdef RAM_ARBITER_RR_EN
  // On a tie the requester that did not win last time goes next.
  assign o_win = (i_req == 2'b11) ? ~i_last : i_req[1];
`else
  assign o_win = i_req[1] & ~i_req[0];
`endif

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter -- two-requester burst arbiter sequencing whole bursts onto RAM port A.  Rev 1.0
// Build option RAM_ARBITER_RR_EN: round-robin tie-break (default: S0 fixed priority).
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int LENW  = LENW_DEFAULT
) (
  input wire           CLK,
  input wire           RST,
  ram_arbiter_if.slave bus
);

  logic [1:0]       r_state;
  logic             r_owner;
  logic             r_we;
  logic             r_rvalid;
  logic [WIDTH-1:0] r_addr;
  logic [LENW-1:0]  r_len;
  logic [LENW-1:0]  r_cnt;

  logic             w_any;
  logic             w_win;
  logic             w_burst;
  logic             w_drain;
  logic             w_own;
  logic [WIDTH-1:0] w_addr;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rdata;

`ifdef RAM_ARBITER_RR_EN
  logic r_last;

  ram_arbiter_pick u_pick (
    .i_req  ({bus.S1_REQ, bus.S0_REQ}),
    .i_last (r_last),
    .o_any  (w_any),
    .o_win  (w_win)
  );
`else
  ram_arbiter_pick u_pick (
    .i_req  ({bus.S1_REQ, bus.S0_REQ}),
    .o_any  (w_any),
    .o_win  (w_win)
  );
`endif

  assign w_burst = (r_state == ST_BURST);
  assign w_drain = (r_state == ST_DRAIN);
  assign w_own   = w_burst | w_drain;
  assign w_addr  = r_addr + WIDTH'(r_cnt);
  assign w_wdata = (r_owner == REQ_S1) ? bus.S1_WDATA : bus.S0_WDATA;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= ST_IDLE;
      r_owner  <= REQ_S0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
`ifdef RAM_ARBITER_RR_EN
      r_last   <= REQ_S1;
`endif
    end else begin
      r_rvalid <= w_burst & ~r_we;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_we    <= w_win ? bus.S1_WE   : bus.S0_WE;
            r_addr  <= w_win ? bus.S1_ADDR : bus.S0_ADDR;
            r_len   <= w_win ? bus.S1_LEN  : bus.S0_LEN;
            r_cnt   <= '0;
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Compare before incrementing so a full-length burst never wraps the counter.
          if (r_cnt == r_len) begin
            r_cnt   <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
`ifdef RAM_ARBITER_RR_EN
          r_last  <= r_owner;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.S0_GNT    = w_own   & (r_owner == REQ_S0);
  assign bus.S1_GNT    = w_own   & (r_owner == REQ_S1);
  assign bus.S0_BEAT   = w_burst & (r_owner == REQ_S0);
  assign bus.S1_BEAT   = w_burst & (r_owner == REQ_S1);
  assign bus.S0_DONE   = w_drain & (r_owner == REQ_S0);
  assign bus.S1_DONE   = w_drain & (r_owner == REQ_S1);
  assign bus.S0_RVALID = r_rvalid & (r_owner == REQ_S0);
  assign bus.S1_RVALID = r_rvalid & (r_owner == REQ_S1);

  // Read data is shared; zeroed when no read is returning so idle outputs stay quiet.
  assign w_rdata      = r_rvalid ? bus.M_RDATA : 32'h0;
  assign bus.S0_RDATA = w_rdata;
  assign bus.S1_RDATA = w_rdata;

  assign bus.M_RDEN  = w_burst & ~r_we;
  assign bus.M_WREN  = w_burst &  r_we;
  assign bus.M_RADDR = (w_burst & ~r_we) ? w_addr  : '0;
  assign bus.M_WADDR = (w_burst &  r_we) ? w_addr  : '0;
  assign bus.M_WDATA = (w_burst &  r_we) ? w_wdata : 32'h0;

endmodule

`default_nettype wire
